// File: rtl/any1_issue_dispatch_if.sv
// ----------------------------------------------------------------------------
// any1_issue_dispatch_if
// Bundle between the instruction scheduler, the issue dispatch buffer and the
// functional units.
//   sel_i        scheduler selection: bit6 = none, bits5:0 = ROB id
//   sel_fu_i     class of sel_i (0 ALU, 1 FPU, 2 MEM; >=NFU maps to 0)
//   flush_i      branch-miss flush
//   fu_valid_o   per-unit request valid
//   fu_rid_o     per-unit ROB id, unit k in bits 6k+5:6k
//   fu_ready_i   per-unit accept
//   full_o       per-class FIFO full (registered)
//   ovf_o        sticky overflow (selection dropped)
//   issued_o     pulse: a selection was accepted on the previous edge
//   issued_rid_o ROB id of that accepted selection
// master = scheduler/unit side, slave = dispatch block.
// ----------------------------------------------------------------------------
interface any1_issue_dispatch_if #(
    parameter int NFU = 3
);
    logic [6:0]       sel_i;
    logic [1:0]       sel_fu_i;
    logic             flush_i;
    logic [NFU-1:0]   fu_valid_o;
    logic [6*NFU-1:0] fu_rid_o;
    logic [NFU-1:0]   fu_ready_i;
    logic [NFU-1:0]   full_o;
    logic             ovf_o;
    logic             issued_o;
    logic [5:0]       issued_rid_o;

    modport master (
        output sel_i, sel_fu_i, flush_i, fu_ready_i,
        input  fu_valid_o, fu_rid_o, full_o, ovf_o, issued_o, issued_rid_o
    );

    modport slave (
        input  sel_i, sel_fu_i, flush_i, fu_ready_i,
        output fu_valid_o, fu_rid_o, full_o, ovf_o, issued_o, issued_rid_o
    );
endinterface

// File: rtl/any1_issue_dispatch.sv
// ----------------------------------------------------------------------------
// any1_issue_dispatch
// Per-class issue buffer between the scheduler and the functional units.
// Each class owns an output register (what the unit sees) backed by a FIFO of
// QDEPTH entries. A selection goes straight into a free, empty class
// (bypass), otherwise it is queued; it is dropped (sticky ovf_o) only when
// the output register is held and the FIFO is full.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    any1_issue_dispatch_if.slave (see interface header)
// ----------------------------------------------------------------------------
module any1_issue_dispatch #(
    parameter int QDEPTH = 4,
    parameter int NFU    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    any1_issue_dispatch_if.slave        bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    // A flush swallows any same-cycle selection, so it never reaches a class.
    logic                  w_sel_v;
    logic [1:0]            w_cls;
    logic [NFU-1:0]        w_v;
    logic [NFU-1:0][5:0]   w_rid;
    logic [NFU-1:0]        w_full;
    logic [NFU-1:0]        w_acc;
    logic [NFU-1:0]        w_drop;

    logic                  r_ovf;
    logic                  r_iss;
    logic [5:0]            r_iss_rid;

    assign w_sel_v = ~bus.sel_i[6] & ~bus.flush_i;
    assign w_cls   = (32'(bus.sel_fu_i) >= NFU) ? 2'd0 : bus.sel_fu_i;

    for (genvar c = 0; c < NFU; c++) begin : g_cls
        logic [5:0]    r_mem [QDEPTH];
        logic [AW-1:0] r_wp, r_rp;
        logic [CW-1:0] r_cnt, w_cnt_nxt;
        logic          r_v, r_full;
        logic [5:0]    r_rid;
        logic          w_hit, w_xfer, w_free, w_empty, w_pop, w_byp, w_push;

        assign w_hit   = w_sel_v & (w_cls == 2'(c));
        assign w_xfer  = r_v & bus.fu_ready_i[c];
        assign w_free  = ~r_v | w_xfer;
        assign w_empty = (r_cnt == '0);
        assign w_pop   = w_free & ~w_empty;
        assign w_byp   = w_free & w_empty & w_hit;
        // A pop in the same cycle makes room, so a full FIFO can still take
        // the selection when the output register is draining.
        assign w_push  = w_hit & ~w_byp & ((r_cnt != CW'(QDEPTH)) | w_pop);

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (w_push & ~w_pop)      w_cnt_nxt = r_cnt + 1'b1;
            else if (w_pop & ~w_push) w_cnt_nxt = r_cnt - 1'b1;
        end

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wp] <= bus.sel_i[5:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wp   <= '0;
                r_rp   <= '0;
                r_cnt  <= '0;
                r_v    <= 1'b0;
                r_rid  <= '0;
                r_full <= 1'b0;
            end else if (bus.flush_i) begin
                r_wp   <= '0;
                r_rp   <= '0;
                r_cnt  <= '0;
                r_v    <= 1'b0;
                r_full <= 1'b0;
            end else begin
                if (w_push) r_wp <= r_wp + 1'b1;
                if (w_pop)  r_rp <= r_rp + 1'b1;
                r_cnt  <= w_cnt_nxt;
                r_full <= (w_cnt_nxt == CW'(QDEPTH));
                if (w_pop) begin
                    r_v   <= 1'b1;
                    r_rid <= r_mem[r_rp];
                end else if (w_byp) begin
                    r_v   <= 1'b1;
                    r_rid <= bus.sel_i[5:0];
                end else if (w_xfer) begin
                    r_v   <= 1'b0;
                end
            end
        end

        assign w_v[c]    = r_v;
        assign w_rid[c]  = r_rid;
        assign w_full[c] = r_full;
        assign w_acc[c]  = w_byp | w_push;
        assign w_drop[c] = w_hit & ~w_free & (r_cnt == CW'(QDEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf     <= 1'b0;
            r_iss     <= 1'b0;
            r_iss_rid <= '0;
        end else begin
            r_ovf <= r_ovf | (|w_drop);
            r_iss <= |w_acc;
            if (|w_acc) r_iss_rid <= bus.sel_i[5:0];
        end
    end

    assign bus.fu_valid_o   = w_v;
    assign bus.fu_rid_o     = w_rid;
    assign bus.full_o       = w_full;
    assign bus.ovf_o        = r_ovf;
    assign bus.issued_o     = r_iss;
    assign bus.issued_rid_o = r_iss_rid;
endmodule

// File: doc/any1_issue_dispatch.md
# any1_issue_dispatch

Per-class issue buffer between the instruction scheduler and the functional units. Each cycle it accepts one selection in the scheduler encoding: 7 bits, bit 6 = none, bits 5:0 = ROB id. Each selection is tagged with a functional-unit class. The block queues it in that class's FIFO and presents it to the ALU, FPU or MEM unit with a valid/ready handshake, so back-to-back selections are not lost while a unit is busy.

## Interface
- QDEPTH, 4: entries per class FIFO, excluding the output register; power of two, 2..8.
- NFU, 3: number of classes/units; class 0 = ALU, 1 = FPU, 2 = MEM.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sel_i  in  7  scheduler selection; bit6=1 means no selection, bits5:0 = ROB id.
- sel_fu_i  in  2  class of sel_i; values 3 and above are treated as class 0.
- flush_i  in  1  branch-miss flush; discards all queued and presented work.
- fu_valid_o  out  NFU  per-unit request valid.
- fu_rid_o  out  6*NFU  per-unit ROB id; unit k occupies bits 6k+5:6k.
- fu_ready_i  in  NFU  per-unit accept.
- full_o  out  NFU  registered; class FIFO holds QDEPTH entries.
- ovf_o  out  1  sticky; a selection was dropped because its class was full.
- issued_o  out  1  one-cycle pulse; a selection was accepted on the previous edge.
- issued_rid_o  out  6  ROB id of that accepted selection; drives the ROB "out" flag.

## Operation
- Selection is valid when sel_i[6]==0. Its class c = (sel_fu_i>=NFU) ? 0 : sel_fu_i.
- Per class, an output register (valid, rid) feeds fu_valid_o/fu_rid_o, backed by a FIFO of QDEPTH entries with a count of 0..QDEPTH.
- Handshake:
  - A transfer on unit k occurs in a cycle where fu_valid_o[k] & fu_ready_i[k].
  - fu_valid_o and fu_rid_o hold stable until the transfer.
  - fu_ready_i without valid is ignored.
- Output register refill, evaluated per class each edge. The register is "free" if it is invalid or transferring this cycle.
  - Free and FIFO non-empty: load the FIFO head and pop.
  - Free, FIFO empty and a class-c selection arrives: load the selection directly (bypass).
  - Otherwise: a class-c selection is pushed to the FIFO if count<QDEPTH.
  - Simultaneous push and pop on one FIFO: count unchanged, order preserved.
- Full drop: a class-c selection arrives while the output register is not free and count==QDEPTH.
  - The selection is discarded and ovf_o is set.
  - ovf_o is cleared only by reset; flush does not clear it.
  - No issued_o pulse is generated for the dropped selection.
- issued_o/issued_rid_o register every accepted selection, whether bypassed or pushed.
- Per-class ordering: units receive ROB ids in arrival order. There is no ordering across classes.
- Flush (flush_i=1 at an edge) has priority over everything else:
  - all counts go to 0, all output valids go to 0, and FIFO pointers reset;
  - any selection in the same cycle is dropped without setting ovf_o, and issued_o is 0 next cycle;
  - a transfer completing in the flush cycle is still counted as taken by the unit.
- full_o[c] is registered as (count_next==QDEPTH).
- FIFO pointers are log2(QDEPTH) bits and wrap modulo QDEPTH. Count is log2(QDEPTH)+1 bits.
- Reset values: fu_valid_o=0, fu_rid_o=0, full_o=0, ovf_o=0, issued_o=0, issued_rid_o=0, all counts and pointers 0.
- Reset asserted mid-operation clears all state immediately, asynchronously. The first edge after rst_n rises may accept a selection.

## Timing
- Bypass latency: selection in cycle N gives fu_valid_o high in cycle N+1.
- Queued latency: at least 2 cycles.
- A unit holding fu_ready_i=1 continuously receives one item per cycle with no bubbles.
- The scheduler treats full_o as one cycle late. Because of this, a selection made in the same cycle full_o rises can overflow.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset, then sel_i=7'h05 with class 0 at cycle 1, fu_ready_i=3'b111:
  - fu_valid_o=3'b001 and fu_rid_o[5:0]=5 in cycle 2;
  - issued_o=1 with issued_rid_o=5 in cycle 2;
  - fu_valid_o=0 in cycle 3.
- fu_ready_i[2]=0; send MEM ids 10,11,12,13,14 on consecutive cycles:
  - 10 is held in the output register;
  - full_o[2]=1 after id 14;
  - raise ready: ids 10..14 appear on consecutive cycles, in order.
- With MEM class full and unready, send MEM id 20: ovf_o=1, no issued_o pulse for 20, and the queue contents are unchanged.
- Interleave ALU id 1, FPU id 2, ALU id 3 with fu_ready_i[0] toggling:
  - ALU sees 1 then 3;
  - FPU sees 2 in the cycle after it arrives;
  - fu_rid_o values stay stable while fu_ready_i[0]=0.
- Queue 3 ALU entries, then assert flush_i together with sel_i=7'h07:
  - next cycle fu_valid_o=0, full_o=0 and issued_o=0;
  - id 7 is never presented.
- sel_fu_i=3 with id 30: id 30 is presented on unit 0. Pull rst_n low mid-queue: all outputs go to 0 immediately.
